mmio_bus_arbiter: RTL and testbench

//  Shares the single FPro MMIO bus (into mmio_sys_vanilla / chu_mmio_controller) between two masters.

---
 rtl/mmio_bus_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mmio_bus_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_bus_arbiter.sv
// Two-master arbiter for the FPro MMIO bus: serialises req/ack transactions into
// single-cycle cs/rd/wr strobes and captures read data into per-master registers.
module mmio_bus_arbiter #(
    parameter int RD_LAT     = 0,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [20:0] m0_addr,
    input  logic [31:0] m0_wr_data,
    output logic [31:0] m0_rd_data,
    output logic        m0_ack,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [20:0] m1_addr,
    input  logic [31:0] m1_wr_data,
    output logic [31:0] m1_rd_data,
    output logic        m1_ack,
    output logic        mmio_cs,
    output logic        mmio_wr,
    output logic        mmio_rd,
    output logic [20:0] mmio_addr,
    output logic [31:0] mmio_wr_data,
    input  logic [31:0] mmio_rd_data,
    output logic        grant,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] LAT_INIT  = 8'(RD_LAT);
    localparam bit         RD_NOWAIT = (RD_LAT == 0);

    state_t      state_r;
    state_t      state_s;
    logic        last_grant_r;
    logic        op_r;
    logic [7:0]  cnt_r;
    logic        any_req_s;
    logic        win_s;
    logic        win_wr_s;
    logic [20:0] win_addr_s;
    logic [31:0] win_wdata_s;
    logic        finish_s;
    logic        capture_s;

    // Winner selection and attribute mux for the IDLE decision
    always_comb begin
        any_req_s = m0_req | m1_req;
        if (m0_req && m1_req) begin
            win_s = FIXED_PRIO ? 1'b0 : ~last_grant_r;
        end else if (m1_req) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
        win_wr_s    = win_s ? m1_wr      : m0_wr;
        win_addr_s  = win_s ? m1_addr    : m0_addr;
        win_wdata_s = win_s ? m1_wr_data : m0_wr_data;
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (op_r || RD_NOWAIT) begin
                    state_s = DONE;
                end else begin
                    state_s = WAIT;
                end
            end
            WAIT: begin
                if (cnt_r <= 8'd1) begin
                    state_s = DONE;
                end else begin
                    state_s = WAIT;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
        // Entering DONE marks the end of the bus phase; reads capture on that same edge
        finish_s  = (state_s == DONE) && (state_r != DONE);
        capture_s = finish_s && !op_r;
    end

    // State register, latched transaction and registered bus/ack outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;
            op_r         <= 1'b0;
            cnt_r        <= 8'd0;
            grant        <= 1'b0;
            busy         <= 1'b0;
            mmio_cs      <= 1'b0;
            mmio_wr      <= 1'b0;
            mmio_rd      <= 1'b0;
            mmio_addr    <= 21'd0;
            mmio_wr_data <= 32'd0;
            m0_ack       <= 1'b0;
            m1_ack       <= 1'b0;
            m0_rd_data   <= 32'd0;
            m1_rd_data   <= 32'd0;
        end else begin
            state_r <= state_s;
            busy    <= (state_s != IDLE);
            mmio_cs <= 1'b0;
            mmio_wr <= 1'b0;
            mmio_rd <= 1'b0;
            m0_ack  <= 1'b0;
            m1_ack  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (any_req_s) begin
                        grant        <= win_s;
                        op_r         <= win_wr_s;
                        mmio_addr    <= win_addr_s;
                        mmio_wr_data <= win_wdata_s;
                        mmio_cs      <= 1'b1;
                        mmio_wr      <= win_wr_s;
                        mmio_rd      <= ~win_wr_s;
                        cnt_r        <= LAT_INIT;
                    end
                end
                WAIT:    cnt_r <= cnt_r - 8'd1;
                DONE:    last_grant_r <= grant;
                default: ;
            endcase
            if (finish_s) begin
                mmio_addr    <= 21'd0;
                mmio_wr_data <= 32'd0;
                m0_ack       <= ~grant;
                m1_ack       <= grant;
            end
            if (capture_s && !grant) begin
                m0_rd_data <= mmio_rd_data;
            end
            if (capture_s && grant) begin
                m1_rd_data <= mmio_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Scoreboard bench: u_rr (RD_LAT=0, round-robin) and u_fp (RD_LAT=2, fixed priority),
// driven one at a time; a negedge monitor pops expected strobes/acks from queues.
module tb_mmio_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [2];
    logic        req [2][2];
    logic        wr_i [2][2];
    logic [20:0] addr_i [2][2];
    logic [31:0] wdata_i [2][2];
    logic [31:0] rdd [2][2];
    logic        ack [2][2];
    logic        cs [2];
    logic        bwr [2];
    logic        brd [2];
    logic        grant [2];
    logic        busy [2];
    logic [20:0] baddr [2];
    logic [31:0] bwdata [2];
    logic [31:0] brdata [2];

    int cyc = 0;
    int since = 0;
    int cs_prev [2];
    int cs_last [2];
    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] model [2][2];

    typedef struct {
        int          d;
        int          m;
        bit          w;
        logic [20:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
    } txn_t;
    txn_t sq[$];
    txn_t aq[$];

    function automatic logic [31:0] slot(input logic [20:0] a);
        if (a == 21'h083) return 32'h0000_1234;
        return 32'hC0DE_0000 | {11'd0, a};
    endfunction

    function automatic logic [31:0] wd_of(input logic [20:0] a);
        if (a == 21'h0C0) return 32'h0000_00A5;
        return 32'hD000_0000 | {11'd0, a};
    endfunction

    // Slot model; the RD_LAT=2 instance adds cycles-since-strobe so the sample cycle is visible
    assign brdata[0] = slot(baddr[0]);
    assign brdata[1] = slot(baddr[1]) + 32'(since);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst[1]) since <= 0;
        else if (cs[1]) since <= 1;
        else if (since != 0 && since < 15) since <= since + 1;
    end

    mmio_bus_arbiter #(.RD_LAT(0), .FIXED_PRIO(1'b0)) u_rr (
        .clk(clk), .reset(rst[0]),
        .m0_req(req[0][0]), .m0_wr(wr_i[0][0]), .m0_addr(addr_i[0][0]), .m0_wr_data(wdata_i[0][0]),
        .m0_rd_data(rdd[0][0]), .m0_ack(ack[0][0]),
        .m1_req(req[0][1]), .m1_wr(wr_i[0][1]), .m1_addr(addr_i[0][1]), .m1_wr_data(wdata_i[0][1]),
        .m1_rd_data(rdd[0][1]), .m1_ack(ack[0][1]),
        .mmio_cs(cs[0]), .mmio_wr(bwr[0]), .mmio_rd(brd[0]), .mmio_addr(baddr[0]),
        .mmio_wr_data(bwdata[0]), .mmio_rd_data(brdata[0]), .grant(grant[0]), .busy(busy[0])
    );

    mmio_bus_arbiter #(.RD_LAT(2), .FIXED_PRIO(1'b1)) u_fp (
        .clk(clk), .reset(rst[1]),
        .m0_req(req[1][0]), .m0_wr(wr_i[1][0]), .m0_addr(addr_i[1][0]), .m0_wr_data(wdata_i[1][0]),
        .m0_rd_data(rdd[1][0]), .m0_ack(ack[1][0]),
        .m1_req(req[1][1]), .m1_wr(wr_i[1][1]), .m1_addr(addr_i[1][1]), .m1_wr_data(wdata_i[1][1]),
        .m1_rd_data(rdd[1][1]), .m1_ack(ack[1][1]),
        .mmio_cs(cs[1]), .mmio_wr(bwr[1]), .mmio_rd(brd[1]), .mmio_addr(baddr[1]),
        .mmio_wr_data(bwdata[1]), .mmio_rd_data(brdata[1]), .grant(grant[1]), .busy(busy[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int d, input int m, input bit w, input logic [20:0] a,
                        input logic [31:0] rd, input bit with_ack);
        txn_t e;
        e.d = d; e.m = m; e.w = w; e.a = a; e.wd = wd_of(a); e.rd = rd;
        sq.push_back(e);
        if (with_ack) aq.push_back(e);
    endtask

    // Monitor: every strobe and every ack must match the head of its queue
    always @(negedge clk) begin : monitor
        txn_t e;
        for (int d = 0; d < 2; d++) begin
            if (cs[d] === 1'b1) begin
                cs_prev[d] = cs_last[d];
                cs_last[d] = cyc;
                if (sq.size() == 0) begin
                    check("unexpected_strobe", 64'(cs[d]), 64'd0);
                end else begin
                    e = sq.pop_front();
                    check("strobe_dut", 64'(d), 64'(e.d));
                    check("strobe_wr", 64'(bwr[d]), 64'(e.w));
                    check("strobe_rd", 64'(brd[d]), 64'(!e.w));
                    check("strobe_addr", 64'(baddr[d]), 64'(e.a));
                    if (e.w) check("strobe_wdata", 64'(bwdata[d]), 64'(e.wd));
                end
            end
            if (ack[d][0] === 1'b1 || ack[d][1] === 1'b1) begin
                if (aq.size() == 0) begin
                    check("unexpected_ack", 64'({ack[d][1], ack[d][0]}), 64'd0);
                end else begin
                    e = aq.pop_front();
                    check("ack_dut", 64'(d), 64'(e.d));
                    check("ack_winner_only", 64'({ack[d][1], ack[d][0]}), (e.m == 1) ? 64'd2 : 64'd1);
                    check("ack_grant", 64'(grant[d]), 64'(e.m));
                    if (!e.w) model[d][e.m] = e.rd;
                    check("rd_data_m0", 64'(rdd[d][0]), 64'(model[d][0]));
                    check("rd_data_m1", 64'(rdd[d][1]), 64'(model[d][1]));
                    check("bus_idle_at_ack",
                          64'({cs[d], bwr[d], brd[d], baddr[d], bwdata[d]}), 64'd0);
                end
            end
        end
    end

    task automatic master_run(input int d, input int m, input int n, input bit w,
                              input logic [20:0] base, output int lat);
        int t;
        int t0;
        lat = -1;
        @(negedge clk);
        wr_i[d][m] = w; addr_i[d][m] = base; wdata_i[d][m] = wd_of(base); req[d][m] = 1'b1;
        t0 = cyc;
        for (int i = 0; i < n; i++) begin
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (ack[d][m] !== 1'b1 && t < 40);
            check("ack_within_bound", 64'(ack[d][m] === 1'b1), 64'd1);
            if (i == 0) lat = cyc - t0;
            if (i < n - 1) begin
                addr_i[d][m]  = base + 21'(i + 1);
                wdata_i[d][m] = wd_of(base + 21'(i + 1));
            end else begin
                req[d][m] = 1'b0;
            end
        end
    endtask

    task automatic do_reset(input int d);
        @(negedge clk);
        rst[d] = 1'b1;
        @(negedge clk);
        check("rst_busy_grant", 64'({busy[d], grant[d]}), 64'd0);
        check("rst_strobes_acks", 64'({cs[d], bwr[d], brd[d], ack[d][0], ack[d][1]}), 64'd0);
        check("rst_bus", 64'({baddr[d], bwdata[d]}), 64'd0);
        check("rst_rd_data", {rdd[d][1], rdd[d][0]}, 64'd0);
        rst[d] = 1'b0;
        model[d][0] = 32'd0;
        model[d][1] = 32'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int lat_a;
        int lat_b;
        int t0;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1;
            cs_prev[d] = 0;
            cs_last[d] = 0;
            for (int m = 0; m < 2; m++) begin
                req[d][m] = 1'b0; wr_i[d][m] = 1'b0; addr_i[d][m] = 21'd0; wdata_i[d][m] = 32'd0;
                model[d][m] = 32'd0;
            end
        end
        do_reset(0);
        do_reset(1);

        // m0 write, then m0 read, then m1 read of the 0x1234 slot
        push(0, 0, 1'b1, 21'h0C0, 32'd0, 1'b1);
        master_run(0, 0, 1, 1'b1, 21'h0C0, lat);
        check("t1_write_latency", 64'(lat), 64'd2);
        push(0, 0, 1'b0, 21'h0C0, 32'hC0DE_00C0, 1'b1);
        master_run(0, 0, 1, 1'b0, 21'h0C0, lat);
        check("m0_read_latency", 64'(lat), 64'd2);
        push(0, 1, 1'b0, 21'h083, 32'h0000_1234, 1'b1);
        master_run(0, 1, 1, 1'b0, 21'h083, lat);
        check("t2_read_latency", 64'(lat), 64'd2);
        check("t2_m1_rd_data", 64'(rdd[0][1]), 64'h1234);

        // Round-robin contention: m0,m1,m0,m1
        push(0, 0, 1'b1, 21'h010, 32'd0, 1'b1);
        push(0, 1, 1'b1, 21'h020, 32'd0, 1'b1);
        push(0, 0, 1'b1, 21'h011, 32'd0, 1'b1);
        push(0, 1, 1'b1, 21'h021, 32'd0, 1'b1);
        fork
            master_run(0, 0, 2, 1'b1, 21'h010, lat_a);
            master_run(0, 1, 2, 1'b1, 21'h020, lat_b);
        join
        check("t3_rr_m0_first", 64'(lat_a), 64'd2);
        check("t3_rr_m1_second", 64'(lat_b), 64'd5);

        // Back-to-back writes from m0 with req held across ack
        push(0, 0, 1'b1, 21'h300, 32'd0, 1'b1);
        push(0, 0, 1'b1, 21'h301, 32'd0, 1'b1);
        master_run(0, 0, 2, 1'b1, 21'h300, lat);
        check("t6_strobe_spacing", 64'(cs_last[0] - cs_prev[0]), 64'd3);

        // Fixed priority with RD_LAT=2: m0 wins all three contended grants
        push(1, 0, 1'b0, 21'h100, 32'hC0DE_0102, 1'b1);
        push(1, 0, 1'b0, 21'h101, 32'hC0DE_0103, 1'b1);
        push(1, 0, 1'b0, 21'h102, 32'hC0DE_0104, 1'b1);
        push(1, 1, 1'b0, 21'h200, 32'hC0DE_0202, 1'b1);
        fork
            master_run(1, 0, 3, 1'b0, 21'h100, lat_a);
            master_run(1, 1, 1, 1'b0, 21'h200, lat_b);
        join
        check("t3_fp_m0_latency", 64'(lat_a), 64'd4);
        check("t3_fp_m1_last", 64'(lat_b), 64'd19);

        // RD_LAT=2 read timing, cycle by cycle
        push(1, 0, 1'b0, 21'h140, 32'hC0DE_0142, 1'b1);
        @(negedge clk);
        wr_i[1][0] = 1'b0; addr_i[1][0] = 21'h140; wdata_i[1][0] = wd_of(21'h140); req[1][0] = 1'b1;
        t0 = cyc;
        @(negedge clk);
        check("t4_issue_cs_rd", 64'({cs[1], brd[1], bwr[1]}), 64'd6);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t4_wait_addr_held", 64'(baddr[1]), 64'h140);
            check("t4_wait_quiet", 64'({cs[1], brd[1], bwr[1], ack[1][0], ack[1][1]}), 64'd0);
        end
        @(negedge clk);
        check("t4_ack", 64'(ack[1][0]), 64'd1);
        check("t4_latency", 64'(cyc - t0), 64'd4);
        req[1][0] = 1'b0;

        // Reset during WAIT: no ack, registers cleared, next request completes
        push(1, 1, 1'b0, 21'h0A0, 32'd0, 1'b0);
        @(negedge clk);
        wr_i[1][1] = 1'b0; addr_i[1][1] = 21'h0A0; wdata_i[1][1] = wd_of(21'h0A0); req[1][1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t5_in_wait", 64'({busy[1], cs[1]}), 64'd2);
        rst[1] = 1'b1;
        req[1][1] = 1'b0;
        @(negedge clk);
        check("t5_busy_cleared", 64'(busy[1]), 64'd0);
        check("t5_no_ack", 64'({ack[1][0], ack[1][1]}), 64'd0);
        check("t5_rd_data_cleared", {rdd[1][1], rdd[1][0]}, 64'd0);
        rst[1] = 1'b0;
        model[1][0] = 32'd0;
        model[1][1] = 32'd0;
        repeat (4) @(negedge clk);
        push(1, 1, 1'b0, 21'h0A0, 32'hC0DE_00A2, 1'b1);
        master_run(1, 1, 1, 1'b0, 21'h0A0, lat);
        check("t5_after_reset_latency", 64'(lat), 64'd4);

        repeat (3) @(negedge clk);
        check("strobe_queue_drained", 64'(sq.size()), 64'd0);
        check("ack_queue_drained", 64'(aq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
